// File: rtl/tmds_to_byte_pkg.sv
// Shared TMDS definitions: the four DVI control tokens, the decoded-character record and the
// alignment FSM states.
package tmds_to_byte_pkg;

  // Control tokens as they appear on input_tmds (bit 0 first on the wire), named by {c1,c0}
  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef struct packed {
    logic       is_ctrl;
    logic       c1;
    logic       c0;
    logic [7:0] data;
  } char_t;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

endpackage

// File: rtl/tmds_to_byte_char_decode.sv
// Combinational 10b TMDS character decode into {is_ctrl, c1, c0, byte}.
// Zero latency; data is 0 for control tokens and c1/c0 are 0 for data characters.
module tmds_to_byte_char_decode
  import tmds_to_byte_pkg::*;
(
  input  logic [9:0] i_char,
  output char_t      o_char
);

  logic [7:0] w_q;
  logic [7:0] w_d;

  always_comb begin
    w_q    = i_char[9] ? ~i_char[7:0] : i_char[7:0];
    w_d    = '0;
    w_d[0] = w_q[0];
    // bit 8 selects XOR (1) or XNOR (0) chaining used by the encoder
    for (int i = 1; i < 8; i++) begin
      w_d[i] = i_char[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

  always_comb begin
    o_char      = '0;
    o_char.data = w_d;
    case (i_char)
      CTRL_TOK_00: begin o_char = '0; o_char.is_ctrl = 1'b1; end
      CTRL_TOK_01: begin o_char = '0; o_char.is_ctrl = 1'b1; o_char.c0 = 1'b1; end
      CTRL_TOK_10: begin o_char = '0; o_char.is_ctrl = 1'b1; o_char.c1 = 1'b1; end
      CTRL_TOK_11: begin o_char = '0; o_char.is_ctrl = 1'b1; o_char.c1 = 1'b1; o_char.c0 = 1'b1; end
      default:     ;
    endcase
  end

endmodule

// File: rtl/tmds_to_byte.sv
// DVI receive channel: finds the 10-bit boundary from control-token runs (bitslip requests), decodes byte or C0/C1.
// Latency 2 cycles, 1 char/cycle, no backpressure; decoded outputs held at 0 while not aligned.
module tmds_to_byte
  import tmds_to_byte_pkg::*;
#(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 8,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic [9:0] input_tmds,
  output logic [7:0] output_byte,
  output logic       video_data_enable,
  output logic       c0,
  output logic       c1,
  output logic       aligned,
  output logic       bitslip
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);
  localparam int GAP_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(SEARCH_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SLIP_SETTLE);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(LOCK_TIMEOUT);

  logic [9:0]       r_tmds;
  state_t           r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
  logic [WIN_W-1:0] r_win, w_win_nxt, w_win_inc;
  logic [SET_W-1:0] r_settle, w_settle_nxt, w_settle_inc;
  logic [GAP_W-1:0] r_gap, w_gap_nxt, w_gap_inc;
  logic             w_slip;
  logic             w_lock_nxt;
  char_t            w_char;

  logic [7:0]       r_byte;
  logic             r_vde, r_c0, r_c1, r_aligned, r_bitslip;

  tmds_to_byte_char_decode u_decode (
    .i_char (r_tmds),
    .o_char (w_char)
  );

  assign w_run_inc    = (r_run    == RUN_MAX) ? r_run    : r_run    + RUN_W'(1);
  assign w_win_inc    = (r_win    == WIN_MAX) ? r_win    : r_win    + WIN_W'(1);
  assign w_settle_inc = (r_settle == SET_MAX) ? r_settle : r_settle + SET_W'(1);
  assign w_gap_inc    = (r_gap    == GAP_MAX) ? r_gap    : r_gap    + GAP_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_win_nxt    = r_win;
    w_settle_nxt = r_settle;
    w_gap_nxt    = r_gap;
    w_slip       = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_run_nxt = w_char.is_ctrl ? w_run_inc : '0;
        w_win_nxt = w_win_inc;
        // a completed run wins over an expiring window in the same cycle
        if (w_char.is_ctrl && (w_run_inc == RUN_MAX)) begin
          w_state_nxt = ST_LOCKED;
          w_run_nxt   = '0;
          w_win_nxt   = '0;
          w_gap_nxt   = '0;
        end else if (r_win == WIN_LAST) begin
          w_state_nxt  = ST_SLIP_WAIT;
          w_slip       = 1'b1;
          w_run_nxt    = '0;
          w_win_nxt    = '0;
          w_settle_nxt = '0;
        end
      end
      ST_SLIP_WAIT: begin
        w_settle_nxt = w_settle_inc;
        if (r_settle == SET_LAST) begin
          w_state_nxt  = ST_SEARCH;
          w_settle_nxt = '0;
        end
      end
      ST_LOCKED: begin
        w_gap_nxt = w_char.is_ctrl ? '0 : w_gap_inc;
        if (!w_char.is_ctrl && (w_gap_inc == GAP_MAX)) begin
          w_state_nxt = ST_SEARCH;
          w_gap_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  // outputs are gated by the next state so they agree with aligned on the same cycle
  assign w_lock_nxt = (w_state_nxt == ST_LOCKED);

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmds    <= '0;
      r_state   <= ST_SEARCH;
      r_run     <= '0;
      r_win     <= '0;
      r_settle  <= '0;
      r_gap     <= '0;
      r_byte    <= '0;
      r_vde     <= 1'b0;
      r_c0      <= 1'b0;
      r_c1      <= 1'b0;
      r_aligned <= 1'b0;
      r_bitslip <= 1'b0;
    end else begin
      r_tmds    <= input_tmds;
      r_state   <= w_state_nxt;
      r_run     <= w_run_nxt;
      r_win     <= w_win_nxt;
      r_settle  <= w_settle_nxt;
      r_gap     <= w_gap_nxt;
      r_byte    <= w_lock_nxt ? w_char.data : 8'h00;
      r_vde     <= w_lock_nxt & ~w_char.is_ctrl;
      r_c0      <= w_lock_nxt & w_char.c0;
      r_c1      <= w_lock_nxt & w_char.c1;
      r_aligned <= w_lock_nxt;
      r_bitslip <= w_slip;
    end
  end

  assign output_byte       = r_byte;
  assign video_data_enable = r_vde;
  assign c0                = r_c0;
  assign c1                = r_c1;
  assign aligned           = r_aligned;
  assign bitslip           = r_bitslip;

endmodule
